// File: rtl/fetch_pc_unit.sv
// Fetch PC stage: holds the fetch PC, issues one instruction-memory read at a time and hands words to decode.
// Define FETCH_REDIRECT_COUNTER_EN to add the saturating redirect_count output.

typedef enum logic {
    PcPlus4             = 1'b0,
    PcOrReadDataPlusImm = 1'b1
} pc_src_t;

module fetch_pc_unit #(
    parameter int unsigned      Width     = 64,
    parameter logic [Width-1:0] ResetAddr = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  pc_src_t          pc_src,
    input  logic             branch_valid,
    input  logic [Width-1:0] target_addr,
    input  logic             stall,
    output logic             inst_mem_rd_en,
    output logic [Width-1:0] inst_mem_addr,
    input  logic             inst_mem_ack,
    input  logic [31:0]      inst_mem_rd_dat,
    output logic [31:0]      inst,
    output logic [Width-1:0] inst_pc,
    output logic             inst_valid,
    output logic             flush,
`ifdef FETCH_REDIRECT_COUNTER_EN
    output logic [31:0]      redirect_count,
`endif
    output logic             misaligned
);

    typedef enum logic [2:0] {
        Idle,
        Req,
        Wait,
        Hold,
        Drain
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [Width-1:0] pc;
    logic [Width-1:0] pc_n;
    logic [31:0]      inst_n;
    logic [Width-1:0] inst_pc_n;
    logic             inst_valid_n;

    logic             redirect;
    logic             redirect_accept;
    logic             redirect_reject;
    logic [Width-1:0] redirect_target;

    // A target with bit 1 set is not 4-byte reachable, so it is refused rather than truncated.
    assign redirect        = branch_valid && (pc_src == PcOrReadDataPlusImm);
    assign redirect_reject = redirect && target_addr[1];
    assign redirect_accept = redirect && !target_addr[1];
    assign redirect_target = target_addr & ~Width'(1);

    assign inst_mem_rd_en = (state == Req);
    assign inst_mem_addr  = pc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= Idle;
            pc         <= ResetAddr;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            flush      <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            inst       <= inst_n;
            inst_pc    <= inst_pc_n;
            inst_valid <= inst_valid_n;
            flush      <= redirect_accept;
            misaligned <= redirect_reject;
        end
    end

    // inst_valid drops by default; only a fresh ack or a stalled Hold keeps it high.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        inst_n       = inst;
        inst_pc_n    = inst_pc;
        inst_valid_n = 1'b0;

        unique case (state)
            Idle: begin
                state_n = Req;
                if (redirect_accept) begin
                    pc_n = redirect_target;
                end
            end

            Req: begin
                if (redirect_accept) begin
                    pc_n    = redirect_target;
                    state_n = Drain;
                end else begin
                    state_n = Wait;
                end
            end

            Wait: begin
                if (redirect_accept) begin
                    pc_n    = redirect_target;
                    state_n = inst_mem_ack ? Req : Drain;
                end else if (inst_mem_ack) begin
                    inst_n       = inst_mem_rd_dat;
                    inst_pc_n    = pc;
                    inst_valid_n = 1'b1;
                    pc_n         = pc + Width'(4);
                    state_n      = stall ? Hold : Req;
                end
            end

            Hold: begin
                if (redirect_accept) begin
                    pc_n    = redirect_target;
                    state_n = Req;
                end else if (stall) begin
                    inst_valid_n = 1'b1;
                end else begin
                    state_n = Req;
                end
            end

            Drain: begin
                // The stale word still has to come back before the next request may go out.
                if (redirect_accept) begin
                    pc_n = redirect_target;
                end
                if (inst_mem_ack) begin
                    state_n = Req;
                end
            end

            default: begin
                state_n = Idle;
            end
        endcase
    end

`ifdef FETCH_REDIRECT_COUNTER_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            redirect_count <= '0;
        end else if (redirect_accept && (redirect_count != 32'hFFFF_FFFF)) begin
            redirect_count <= redirect_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed scoreboard bench for fetch_pc_unit: expected request addresses and decoded words are queued
// when stimulus is driven and checked as the DUT produces them.

module tb_fetch_pc_unit;

    localparam int Width = 64;

    logic             clock = 1'b0;
    logic             reset;
    pc_src_t          pc_src;
    logic             branch_valid;
    logic [Width-1:0] target_addr;
    logic             stall;
    logic             inst_mem_rd_en;
    logic [Width-1:0] inst_mem_addr;
    logic             inst_mem_ack;
    logic [31:0]      inst_mem_rd_dat;
    logic [31:0]      inst;
    logic [Width-1:0] inst_pc;
    logic             inst_valid;
    logic             flush;
    logic             misaligned;
`ifdef FETCH_REDIRECT_COUNTER_EN
    logic [31:0]      redirect_count;
`endif

    int check_count = 0;
    int pass_count  = 0;

    logic [Width-1:0]    exp_addr_q[$];
    logic [Width+31:0]   exp_inst_q[$];
    logic [Width-1:0]    model_pc;
    logic                flush_pending = 1'b0;
    logic                mis_pending   = 1'b0;
    logic                prev_valid    = 1'b0;

    always #5 clock = ~clock;

    fetch_pc_unit #(
        .Width     (Width),
        .ResetAddr ('0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_src          (pc_src),
        .branch_valid    (branch_valid),
        .target_addr     (target_addr),
        .stall           (stall),
        .inst_mem_rd_en  (inst_mem_rd_en),
        .inst_mem_addr   (inst_mem_addr),
        .inst_mem_ack    (inst_mem_ack),
        .inst_mem_rd_dat (inst_mem_rd_dat),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .flush           (flush),
`ifdef FETCH_REDIRECT_COUNTER_EN
        .redirect_count  (redirect_count),
`endif
        .misaligned      (misaligned)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // One clock edge, then compare everything the DUT produced against the queued expectations.
    task automatic applyStimulus();
        logic [Width+31:0] e;
        @(posedge clock);
        #1;
        checkOutput("flush", 64'(flush), 64'(flush_pending));
        checkOutput("misaligned", 64'(misaligned), 64'(mis_pending));
        flush_pending = 1'b0;
        mis_pending   = 1'b0;
        if (inst_mem_rd_en === 1'b1) begin
            if (exp_addr_q.size() == 0) checkOutput("req_unexpected", 64'(inst_mem_rd_en), 64'd0);
            else checkOutput("req_addr", 64'(inst_mem_addr), 64'(exp_addr_q.pop_front()));
        end
        if (inst_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_inst_q.size() == 0) begin
                checkOutput("inst_unexpected", 64'(inst_valid), 64'd0);
            end else begin
                e = exp_inst_q.pop_front();
                checkOutput("inst_pc", 64'(inst_pc), 64'(e[Width+31:32]));
                checkOutput("inst", 64'(inst), 64'(e[31:0]));
            end
        end
        prev_valid = inst_valid;
    endtask

    task automatic ack_in_wait(input logic [31:0] data, input logic st);
        inst_mem_ack    = 1'b1;
        inst_mem_rd_dat = data;
        stall           = st;
        exp_inst_q.push_back({model_pc, data});
        model_pc = model_pc + 64'd4;
        if (!st) exp_addr_q.push_back(model_pc);
        applyStimulus();
        inst_mem_ack = 1'b0;
    endtask

    task automatic fetch_word(input logic [31:0] data, input logic st);
        applyStimulus();
        ack_in_wait(data, st);
    endtask

    task automatic drive_redirect(input pc_src_t src, input logic [Width-1:0] target);
        branch_valid = 1'b1;
        pc_src       = src;
        target_addr  = target;
        if (src == PcOrReadDataPlusImm) begin
            if (target[1]) begin
                mis_pending = 1'b1;
            end else begin
                flush_pending = 1'b1;
                model_pc      = target & ~64'd1;
                exp_addr_q.push_back(model_pc);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset           = 1'b0;
        pc_src          = PcPlus4;
        branch_valid    = 1'b0;
        target_addr     = '0;
        stall           = 1'b0;
        inst_mem_ack    = 1'b0;
        inst_mem_rd_dat = '0;
        model_pc        = '0;

        // Reset values
        repeat (3) applyStimulus();
        checkOutput("rst_rd_en", 64'(inst_mem_rd_en), 64'd0);
        checkOutput("rst_valid", 64'(inst_valid), 64'd0);
        checkOutput("rst_inst", 64'(inst), 64'd0);
        checkOutput("rst_inst_pc", 64'(inst_pc), 64'd0);

        // First request follows the single Idle cycle
        reset = 1'b1;
        exp_addr_q.push_back(model_pc);
        applyStimulus();
        checkOutput("first_req", 64'(inst_mem_rd_en), 64'd1);

        // Sequential fetch, then a word held under stall
        fetch_word(32'h0000_0013, 1'b0);
        fetch_word(32'h0000_0013, 1'b1);
        repeat (2) begin
            applyStimulus();
            checkOutput("hold_valid", 64'(inst_valid), 64'd1);
            checkOutput("hold_inst_pc", 64'(inst_pc), 64'h4);
            checkOutput("hold_inst", 64'(inst), 64'h13);
            checkOutput("hold_no_req", 64'(inst_mem_rd_en), 64'd0);
        end
        stall = 1'b0;
        exp_addr_q.push_back(model_pc);
        applyStimulus();
        checkOutput("req_after_stall", 64'(inst_mem_rd_en), 64'd1);
        checkOutput("valid_after_stall", 64'(inst_valid), 64'd0);

        // Redirect in Wait at 0x8, stale ack arrives two cycles later
        applyStimulus();
        drive_redirect(PcOrReadDataPlusImm, 64'h100);
        applyStimulus();
        branch_valid = 1'b0;
        applyStimulus();
        checkOutput("drain_valid", 64'(inst_valid), 64'd0);
        inst_mem_ack    = 1'b1;
        inst_mem_rd_dat = 32'hDEAD_BEEF;
        applyStimulus();
        inst_mem_ack = 1'b0;
        checkOutput("drain_discard", 64'(inst_valid), 64'd0);
        checkOutput("req_at_target", 64'(inst_mem_rd_en), 64'd1);
        fetch_word(32'h0010_0093, 1'b0);

        // Redirect during Req with bit 0 set: target rounds down to 0x200
        drive_redirect(PcOrReadDataPlusImm, 64'h201);
        applyStimulus();
        branch_valid    = 1'b0;
        inst_mem_ack    = 1'b1;
        inst_mem_rd_dat = 32'h5555_5555;
        applyStimulus();
        inst_mem_ack = 1'b0;
        fetch_word(32'h0020_0113, 1'b0);

        // Misaligned target is refused; fetch proceeds at pc+4
        drive_redirect(PcOrReadDataPlusImm, 64'h202);
        applyStimulus();
        branch_valid = 1'b0;
        ack_in_wait(32'h0030_0193, 1'b0);

        // PcPlus4 decision never redirects
        drive_redirect(PcPlus4, 64'h400);
        applyStimulus();
        branch_valid = 1'b0;
        ack_in_wait(32'h0040_0213, 1'b0);

        // Redirect while stalled in Hold overrides the stall
        fetch_word(32'h0050_0293, 1'b1);
        drive_redirect(PcOrReadDataPlusImm, 64'h300);
        applyStimulus();
        branch_valid = 1'b0;
        stall        = 1'b0;
        checkOutput("hold_redirect_valid", 64'(inst_valid), 64'd0);
        checkOutput("hold_redirect_req", 64'(inst_mem_rd_en), 64'd1);

        // Redirect and ack in the same Wait cycle
        applyStimulus();
        drive_redirect(PcOrReadDataPlusImm, 64'h400);
        inst_mem_ack    = 1'b1;
        inst_mem_rd_dat = 32'h0BAD_0BAD;
        applyStimulus();
        branch_valid = 1'b0;
        inst_mem_ack = 1'b0;
        checkOutput("same_cycle_valid", 64'(inst_valid), 64'd0);

`ifdef FETCH_REDIRECT_COUNTER_EN
        checkOutput("redirect_count", 64'(redirect_count), 64'd4);
`endif

        // Reset while Wait is pending; the late ack must be ignored
        applyStimulus();
        reset           = 1'b0;
        inst_mem_ack    = 1'b1;
        inst_mem_rd_dat = 32'hFFFF_FFFF;
        applyStimulus();
        checkOutput("midrst_addr_q", 64'(exp_addr_q.size()), 64'd0);
        checkOutput("midrst_inst_q", 64'(exp_inst_q.size()), 64'd0);
`ifdef FETCH_REDIRECT_COUNTER_EN
        checkOutput("redirect_count_rst", 64'(redirect_count), 64'd0);
`endif
        reset    = 1'b1;
        model_pc = '0;
        exp_addr_q.push_back(model_pc);
        applyStimulus();
        inst_mem_ack = 1'b0;
        checkOutput("stale_ack_valid", 64'(inst_valid), 64'd0);
        checkOutput("post_rst_req", 64'(inst_mem_rd_en), 64'd1);
        fetch_word(32'h0000_0013, 1'b0);

        checkOutput("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
        checkOutput("inst_q_drained", 64'(exp_inst_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
